onehot_mux_reg: RTL

- Parametrised, registered successor to the fixed-width one-hot-select multiplexers in the datapath (8-bit data, 12-bit address, 1-bit flag variants).
- Selects one of N WIDTH-bit inputs by one-hot/priority select.
- Holds the last selected value in a real register when no select is asserted. This replaces the feedback-latch hold.
- Adds select-conflict detection, a hold-age counter and an update strobe for multicycle controller debug.

---
 rtl/onehot_mux_reg.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/onehot_mux_reg.sv
// ---------------------------------------------------------------------------
// onehot_mux_reg
//
// Registered one-hot/priority-select multiplexer. It selects one of N
// WIDTH-bit inputs and holds the last selected value in a real flop when no
// select line is asserted. This replaces the older feedback-latch hold.
// It also exports debug state for multicycle controllers:
//   * an index of the input that was last loaded,
//   * a one-cycle update strobe,
//   * a saturating hold-age counter.
//
// Optional build macro:
//   ONEHOT_MUX_CONFLICT_EN - when defined, the block detects cycles with more
//   than one select bit high. It drives a sticky multi_sel_err flag and a
//   saturating conflict counter. When undefined, both outputs are tied to 0
//   and clr_err is ignored. Priority selection and the port list are the same
//   in both builds.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   in_data        in   N*WIDTH packed inputs, input i = in_data[i*WIDTH +: WIDTH]
//   sel            in   N select lines, lowest set index wins
//   clr_err        in   synchronous clear of multi_sel_err and conflict_cnt
//   out            out  registered selected data
//   sel_idx        out  index of the input last loaded into out
//   updated        out  high for one cycle after out was loaded
//   hold_cnt       out  cycles since the last load, saturating
//   multi_sel_err  out  sticky: more than one sel bit seen high
//   conflict_cnt   out  saturating count of multi-select cycles
// ---------------------------------------------------------------------------
module onehot_mux_reg #(
   parameter int unsigned       WIDTH   = 8,
   parameter int unsigned       N       = 3,
   parameter int unsigned       CNT_W   = 8,
   parameter logic [WIDTH-1:0]  RST_VAL = '0,
   localparam int unsigned      IDX_W   = (N > 2) ? $clog2(N) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         sel,
   input  logic                 clr_err,
   output logic [WIDTH-1:0]     out,
   output logic [IDX_W-1:0]     sel_idx,
   output logic                 updated,
   output logic [CNT_W-1:0]     hold_cnt,
   output logic                 multi_sel_err,
   output logic [CNT_W-1:0]     conflict_cnt
);

   // -----------------------------------------------------------------------
   // Priority selection
   // -----------------------------------------------------------------------
   logic             any_sel;
   logic [IDX_W-1:0] win_idx;
   logic [WIDTH-1:0] win_data;

   // The loop runs from the highest index down, so the lowest set index is
   // written last and wins. Each slice uses a constant index. Unselected
   // inputs never reach win_data, so X/Z on them cannot leak into out.
   always_comb begin
      // NOTE: every combinational output gets a default first; a path that
      // leaves one unassigned would infer a latch.
      any_sel  = |sel;
      win_idx  = '0;
      win_data = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (sel[i]) begin
            win_idx  = IDX_W'(i);
            win_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // -----------------------------------------------------------------------
   // Output register, index, strobe and hold-age counter
   // -----------------------------------------------------------------------
   logic [WIDTH-1:0] out_q,      out_d;
   logic [IDX_W-1:0] sel_idx_q,  sel_idx_d;
   logic             updated_q,  updated_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

   always_comb begin
      out_d      = out_q;
      sel_idx_d  = sel_idx_q;
      updated_d  = 1'b0;
      hold_cnt_d = hold_cnt_q;
      if (any_sel) begin
         // Loading an identical value still counts as a load.
         out_d      = win_data;
         sel_idx_d  = win_idx;
         updated_d  = 1'b1;
         hold_cnt_d = '0;
      end else if (hold_cnt_q != '1) begin
         hold_cnt_d = hold_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples its pre-edge inputs regardless of statement order.
      if (rst) begin
         out_q      <= RST_VAL;
         sel_idx_q  <= '0;
         updated_q  <= 1'b0;
         hold_cnt_q <= '0;
      end else begin
         out_q      <= out_d;
         sel_idx_q  <= sel_idx_d;
         updated_q  <= updated_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign out      = out_q;
   assign sel_idx  = sel_idx_q;
   assign updated  = updated_q;
   assign hold_cnt = hold_cnt_q;

   // -----------------------------------------------------------------------
   // Select-conflict detection (optional)
   // -----------------------------------------------------------------------
`ifdef ONEHOT_MUX_CONFLICT_EN
   logic             multi_sel;
   logic             err_q, err_d;
   logic [CNT_W-1:0] conf_cnt_q, conf_cnt_d;

   // Clearing the lowest set bit leaves something behind only when at least
   // two bits were set, which is the popcount >= 2 test.
   always_comb begin
      multi_sel  = |(sel & (sel - N'(1)));
      err_d      = err_q;
      conf_cnt_d = conf_cnt_q;
      // A clear takes precedence over a conflict seen on the same edge.
      if (clr_err) begin
         err_d      = 1'b0;
         conf_cnt_d = '0;
      end else if (multi_sel) begin
         err_d = 1'b1;
         if (conf_cnt_q != '1) begin
            conf_cnt_d = conf_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q      <= 1'b0;
         conf_cnt_q <= '0;
      end else begin
         err_q      <= err_d;
         conf_cnt_q <= conf_cnt_d;
      end
   end

   assign multi_sel_err = err_q;
   assign conflict_cnt  = conf_cnt_q;
`else
   // The clear input stays on the port list, but nothing consumes it in
   // this build.
   logic unused_clr_err;
   assign unused_clr_err = clr_err;

   assign multi_sel_err = 1'b0;
   assign conflict_cnt  = '0;
`endif

endmodule
